// File: rtl/bounce_gen.sv
// Contact-bounce generator: re-emits clean_in with a burst of LFSR-spaced
// false transitions after every accepted edge, or passes it through when disabled.
module bounce_gen #(
  parameter int          BOUNCE_COUNT = 5,
  parameter int          MAX_GAP      = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic clean_in,
  input  logic enable,
  output logic noisy_out,
  output logic busy
);

  localparam int GAP_W  = $clog2(MAX_GAP);
  localparam int STEPS  = 2 * BOUNCE_COUNT + 1;
  localparam int STEP_W = ($clog2(STEPS + 1) > 0) ? $clog2(STEPS + 1) : 1;

  localparam logic [GAP_W:0]    SEG_ONE      = (GAP_W + 1)'(1);
  localparam logic [STEP_W-1:0] STEP_ONE     = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_PENULT  = STEP_W'(STEPS - 1);

  typedef enum logic {IDLE, BOUNCE} state_t;

  state_t              state, state_next;
  logic                in_q;
  logic                target, target_next;
  logic                noisy_next;
  logic                edge_seen;
  logic [GAP_W:0]      seg_cnt, seg_next, seg_len;
  logic [STEP_W-1:0]   step_cnt, step_next;
  logic [15:0]         lfsr;
  logic                lfsr_fb;

  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign edge_seen = (in_q != target);

  // Segment length 1..MAX_GAP; a single-cycle gap needs no LFSR bits at all.
  generate
    if (GAP_W == 0) begin : g_fixed_gap
      assign seg_len = SEG_ONE;
    end else begin : g_rand_gap
      assign seg_len = {1'b0, lfsr[GAP_W-1:0]} + SEG_ONE;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q      <= 1'b0;
      target    <= 1'b0;
      noisy_out <= 1'b0;
      busy      <= 1'b0;
      state     <= IDLE;
      seg_cnt   <= '0;
      step_cnt  <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      in_q      <= clean_in;
      target    <= target_next;
      noisy_out <= noisy_next;
      busy      <= (state == BOUNCE);
      state     <= state_next;
      seg_cnt   <= seg_next;
      step_cnt  <= step_next;
      lfsr      <= {lfsr[14:0], lfsr_fb};
    end
  end

  // A fresh edge always restarts the burst, even in the middle of one.
  always_comb begin
    state_next  = state;
    target_next = target;
    noisy_next  = noisy_out;
    seg_next    = seg_cnt;
    step_next   = step_cnt;
    if (!enable) begin
      state_next  = IDLE;
      target_next = in_q;
      noisy_next  = in_q;
    end else if (edge_seen) begin
      target_next = in_q;
      if (STEPS == 1) begin
        noisy_next = in_q;
        state_next = IDLE;
      end else begin
        noisy_next = ~noisy_out;
        seg_next   = seg_len;
        step_next  = STEP_ONE;
        state_next = BOUNCE;
      end
    end else if (state == BOUNCE) begin
      if (seg_cnt == SEG_ONE) begin
        step_next = step_cnt + STEP_ONE;
        if (step_cnt == STEP_PENULT) begin
          noisy_next = target;
          state_next = IDLE;
        end else begin
          noisy_next = ~noisy_out;
          seg_next   = seg_len;
        end
      end else begin
        seg_next = seg_cnt - SEG_ONE;
      end
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: three parameterisations driven in lockstep and compared
// every cycle against an event-level reference model, plus directed scenario checks.
module tb_bounce_gen;

  logic clk;
  logic rst;
  logic clean_in;
  logic enable;
  logic noisy_a, busy_a;
  logic noisy_b, busy_b;
  logic noisy_c, busy_c;

  int vectors;
  int miscompares;
  int cyc;
  bit valid;

  typedef struct packed {
    logic        in_q;
    logic        target;
    logic        noisy;
    logic        bouncing;
    logic        busy;
    int          step;
    int          next_at;
    logic [15:0] lfsr;
  } model_t;

  model_t ma, mb, mc;

  bounce_gen dut_a (
    .clk(clk), .rst(rst), .clean_in(clean_in), .enable(enable),
    .noisy_out(noisy_a), .busy(busy_a)
  );

  bounce_gen #(.BOUNCE_COUNT(2), .MAX_GAP(1)) dut_b (
    .clk(clk), .rst(rst), .clean_in(clean_in), .enable(enable),
    .noisy_out(noisy_b), .busy(busy_b)
  );

  bounce_gen #(.BOUNCE_COUNT(0), .MAX_GAP(4)) dut_c (
    .clk(clk), .rst(rst), .clean_in(clean_in), .enable(enable),
    .noisy_out(noisy_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Steps are scheduled as absolute cycle numbers rather than down-counters.
  function automatic model_t model_step(model_t m, int steps, int max_gap,
                                        bit r, bit c, bit en, int now);
    model_t n;
    int     len;
    n = m;
    if (r) begin
      n = '0;
      n.lfsr = 16'hACE1;
      return n;
    end
    len    = int'(m.lfsr % 16'(max_gap)) + 1;
    n.busy = m.bouncing;
    n.in_q = c;
    n.lfsr = {m.lfsr[14:0], m.lfsr[15] ^ m.lfsr[13] ^ m.lfsr[12] ^ m.lfsr[10]};
    if (!en) begin
      n.target   = m.in_q;
      n.noisy    = m.in_q;
      n.bouncing = 1'b0;
    end else if (m.in_q != m.target) begin
      n.target = m.in_q;
      if (steps == 1) begin
        n.noisy = m.in_q;
      end else begin
        n.noisy    = ~m.noisy;
        n.bouncing = 1'b1;
        n.step     = 1;
        n.next_at  = now + len;
      end
    end else if (m.bouncing && now == m.next_at) begin
      n.step = m.step + 1;
      if (n.step == steps) begin
        n.noisy    = m.target;
        n.bouncing = 1'b0;
      end else begin
        n.noisy   = ~m.noisy;
        n.next_at = now + len;
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit c, input bit en);
    rst      = r;
    clean_in = c;
    enable   = en;
    @(posedge clk);
    ma = model_step(ma, 11, 16, r, c, en, cyc);
    mb = model_step(mb, 5, 1, r, c, en, cyc);
    mc = model_step(mc, 1, 4, r, c, en, cyc);
    cyc++;
    if (r) valid = 1'b1;
    #1;
    if (valid) begin
      checkOutput("model_noisy_a", 16'(noisy_a), 16'(ma.noisy));
      checkOutput("model_busy_a",  16'(busy_a),  16'(ma.busy));
      checkOutput("model_noisy_b", 16'(noisy_b), 16'(mb.noisy));
      checkOutput("model_busy_b",  16'(busy_b),  16'(mb.busy));
      checkOutput("model_noisy_c", 16'(noisy_c), 16'(mc.noisy));
      checkOutput("model_busy_c",  16'(busy_c),  16'(mc.busy));
    end
  endtask

  task automatic settle(input int n, input bit c, input bit en);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, c, en);
  endtask

  initial begin
    logic [7:0]  exp_noisy28, exp_busy28;
    logic [9:0]  exp_noisy30, exp_busy30;
    logic        prev_clean, cur_clean, prev_noisy;
    int          toggles, last_toggle, gap;
    bit          r_rand, c_rand, en_rand;

    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    valid       = 1'b0;
    ma = '0; mb = '0; mc = '0;
    rst = 1'b1; clean_in = 1'b1; enable = 1'b1;

    $display("[TB] reset with clean_in high");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("rst_noisy", 16'(noisy_a), 16'd0);
      checkOutput("rst_busy",  16'(busy_a),  16'd0);
      checkOutput("rst_lfsr",  dut_a.lfsr,   16'hACE1);
    end
    settle(200, 1'b1, 1'b1);
    settle(200, 1'b0, 1'b1);

    $display("[TB] basic bounce, two bounces, unit gap");
    exp_noisy28 = 8'b1110_1010;
    exp_busy28  = 8'b0011_1100;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("basic_noisy", 16'(noisy_b), 16'(exp_noisy28[k]));
      checkOutput("basic_busy",  16'(busy_b),  16'(exp_busy28[k]));
    end
    checkOutput("s1_noisy", 16'(noisy_c), 16'd1);

    settle(200, 1'b0, 1'b1);
    $display("[TB] restart mid-bounce");
    exp_noisy30 = 10'b00_0010_1010;
    exp_busy30  = 10'b00_1111_1100;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, (k < 2), 1'b1);
      checkOutput("restart_noisy", 16'(noisy_b), 16'(exp_noisy30[k]));
      checkOutput("restart_busy",  16'(busy_b),  16'(exp_busy30[k]));
    end

    $display("[TB] bypass");
    prev_clean = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cur_clean = ((k / 3) % 2) == 1;
      applyStimulus(1'b0, cur_clean, 1'b0);
      if (k >= 2) begin
        checkOutput("bypass_noisy", 16'(noisy_a), 16'(prev_clean));
        checkOutput("bypass_busy",  16'(busy_a),  16'd0);
      end
      prev_clean = cur_clean;
    end

    settle(20, 1'b0, 1'b1);
    $display("[TB] reset during bounce");
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("pre_rst_busy", 16'(busy_a), 16'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("midrst_noisy", 16'(noisy_a), 16'd0);
    checkOutput("midrst_busy",  16'(busy_a),  16'd0);
    toggles = 0;
    for (int k = 0; k < 40; k++) begin
      prev_noisy = noisy_a;
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (noisy_a !== prev_noisy) toggles++;
    end
    checkOutput("post_rst_toggles", 16'(toggles), 16'd0);

    $display("[TB] default-parameter edge train");
    cur_clean = 1'b0;
    for (int e = 0; e < 100; e++) begin
      cur_clean   = ~cur_clean;
      toggles     = 0;
      last_toggle = 0;
      gap         = 200 + int'($urandom_range(0, 15));
      for (int k = 1; k <= gap; k++) begin
        prev_noisy = noisy_a;
        applyStimulus(1'b0, cur_clean, 1'b1);
        if (noisy_a !== prev_noisy) begin
          toggles++;
          last_toggle = k;
        end
      end
      checkOutput("event_toggles", 16'(toggles), 16'd11);
      checkOutput("event_settled", 16'(noisy_a), 16'(cur_clean));
      if (last_toggle > 2 + 10 * 16)
        checkOutput("event_settle_time", 16'(last_toggle), 16'(2 + 10 * 16));
    end

    $display("[TB] random traffic");
    c_rand  = cur_clean;
    en_rand = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      r_rand = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) c_rand = ~c_rand;
      if ($urandom_range(0, 99) == 0) en_rand = ~en_rand;
      applyStimulus(r_rand, c_rand, en_rand);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 The block SHALL have parameter BOUNCE_COUNT, default 5, giving the number of false-return pulses injected per input edge (0 allowed).
REQ-002 The block SHALL have parameter MAX_GAP, default 16, giving the maximum segment length in cycles; power of 2, at least 1; GAP_W = $clog2(MAX_GAP).
REQ-003 The block SHALL have parameter LFSR_SEED, default 16'hACE1, giving the nonzero LFSR reset value.
REQ-004 Port clk SHALL be: input, 1 bit, single clock; all logic on posedge.
REQ-005 Port rst SHALL be: input, 1 bit, synchronous active-high reset.
REQ-006 Port clean_in SHALL be: input, 1 bit, clean level to be corrupted with bounce.
REQ-007 Port enable SHALL be: input, 1 bit; 1 = inject bounce; 0 = bypass.
REQ-008 Port noisy_out SHALL be: output, 1 bit, registered bouncing version of clean_in.
REQ-009 Port busy SHALL be: output, 1 bit, high while state = BOUNCE.

Function
REQ-010 clean_in SHALL be registered once into in_q; all decisions use in_q.
REQ-011 Registered target SHALL hold the last accepted level; an edge SHALL mean in_q != target.
REQ-012 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL shift every non-reset cycle; segment length L = lfsr[GAP_W-1:0] + 1 (range 1..MAX_GAP; L = 1 when MAX_GAP = 1).
REQ-013 Each bounce event SHALL consist of S = 2*BOUNCE_COUNT+1 steps: steps 1..S-1 invert noisy_out, and step S sets noisy_out = target.
REQ-014 FSM states SHALL be IDLE and BOUNCE only.
REQ-015 In IDLE with enable=1 and an edge, the block SHALL: set target <= in_q; execute step 1 in the same cycle; if S > 1, load seg_cnt with L, set step_cnt = 1, and go to BOUNCE; if S = 1, stay in IDLE.
REQ-016 In BOUNCE, seg_cnt SHALL decrement each cycle; on the cycle it reaches 1, the next step SHALL execute, and seg_cnt SHALL reload with the current L.
REQ-017 On the cycle step S executes, the FSM SHALL return to IDLE.
REQ-018 Consecutive steps SHALL be exactly L cycles apart, using the L sampled at the earlier step.
REQ-019 An edge during BOUNCE SHALL: update target; reset step_cnt to 1; execute step 1 (invert) that cycle; reload seg_cnt. This takes priority over a pending step.
REQ-020 With enable=0, noisy_out <= in_q and target <= in_q every cycle, and the FSM SHALL be forced to IDLE; dropping enable mid-bounce aborts the bounce.
REQ-021 Latency: a clean_in change sampled at edge t SHALL produce the first noisy_out change at edge t+2.
REQ-022 In steady state with no edge, noisy_out SHALL equal target and SHALL never toggle.
REQ-023 Counter widths: seg_cnt SHALL be GAP_W+1 bits; step_cnt SHALL be $clog2(S+1) bits, minimum 1; no wrap is permitted.

Reset
REQ-024 While rst=1, the block SHALL set in_q=0, target=0, noisy_out=0, busy=0, state=IDLE, seg_cnt=0, step_cnt=0, lfsr=LFSR_SEED.
REQ-025 Reset SHALL override every other input, including mid-bounce, and take effect on the same edge.
REQ-026 The first edge after reset release SHALL evaluate normally.

Verification
REQ-027 Reset scenario: hold rst=1 for 2 cycles with clean_in=1 -> noisy_out=0, busy=0, and lfsr=16'hACE1 during reset.
REQ-028 Basic bounce scenario: BOUNCE_COUNT=2, MAX_GAP=1, enable=1, clean_in 0->1 at t -> noisy_out = 1,0,1,0,1 at edges t+2..t+6, busy=1 at t+3..t+6, then noisy_out stays 1.
REQ-029 Bypass scenario: enable=0, toggle clean_in -> noisy_out tracks clean_in with 2-cycle latency, busy=0 throughout.
REQ-030 Restart scenario: BOUNCE_COUNT=2, MAX_GAP=1, clean_in 0->1 then 1->0 two cycles later -> step counting restarts, final noisy_out=0, and no final 1 settle occurs.
REQ-031 Defaults scenario: default parameters, 100 random clean_in edges spaced 200 cycles -> noisy_out reaches target within 2+10*16 cycles of each edge, and toggles per event equal 11 (checked against a reference LFSR model).
REQ-032 Reset mid-bounce scenario: assert rst during BOUNCE -> noisy_out=0, busy=0 next edge, and no residual toggles after release.
